// File: rtl/lbm_pkg.sv
// Shared types and helpers for the lattice sweep sequencer: FSM state encoding,
// default lattice size and the node-count helper used to find the last index.
package lbm_pkg;

    localparam int DEFAULT_GRID_DIM = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        DRAIN,
        ERROR,
        DONE
    } sweep_state_t;

    function automatic int node_count(input int grid_dim);
        return grid_dim * grid_dim;
    endfunction

endpackage

// File: rtl/lattice_boundary_detect.sv
// Combinational lattice-edge detector: flags a node on row/column 0 or GRID_DIM-1.
// Only built when LBM_BOUNDARY_FLAG_EN is defined.
`ifdef LBM_BOUNDARY_FLAG_EN
module lattice_boundary_detect #(
    parameter int GRID_DIM      = 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM * GRID_DIM)
) (
    input  logic [ADDRESS_WIDTH-1:0] row_i,
    input  logic [ADDRESS_WIDTH-1:0] col_i,
    output logic                     boundary_o
);

    localparam logic [ADDRESS_WIDTH-1:0] EDGE_MAX = ADDRESS_WIDTH'(GRID_DIM - 1);

    assign boundary_o = (row_i == '0) || (row_i == EDGE_MAX) ||
                        (col_i == '0) || (col_i == EDGE_MAX);

endmodule
`endif

// File: rtl/lattice_sweep_sequencer.sv
// Sweeps node indices 0..GRID_DIM^2-1 through an external divider and streams
// (index,row,col) tuples out. LBM_BOUNDARY_FLAG_EN adds the node_boundary output.
module lattice_sweep_sequencer
    import lbm_pkg::*;
#(
    parameter int GRID_DIM      = DEFAULT_GRID_DIM,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM * GRID_DIM)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     sweep_start,
    input  logic                     sweep_abort,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic                     sweep_err,
    output logic                     div_start,
    output logic [ADDRESS_WIDTH-1:0] div_x,
    output logic [ADDRESS_WIDTH-1:0] div_y,
    input  logic                     div_busy,
    input  logic                     div_valid,
    input  logic                     div_dbz,
    input  logic                     div_ovf,
    input  logic [ADDRESS_WIDTH-1:0] div_q,
    input  logic [ADDRESS_WIDTH-1:0] div_r,
    output logic                     node_valid,
    input  logic                     node_ready,
    output logic [ADDRESS_WIDTH-1:0] node_index,
    output logic [ADDRESS_WIDTH-1:0] node_row,
    output logic [ADDRESS_WIDTH-1:0] node_col,
`ifdef LBM_BOUNDARY_FLAG_EN
    output logic                     node_boundary,
`endif
    output sweep_state_t             sweep_state
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(node_count(GRID_DIM) - 1);
    localparam logic [ADDRESS_WIDTH-1:0] DIVISOR    = ADDRESS_WIDTH'(GRID_DIM);

    // Downstream handshake: a tuple transfers on a cycle where node_valid and
    // node_ready are both high; node_valid never depends on node_ready.
    sweep_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   index_q, index_d;
    logic                       err_q, err_d;
    logic                       valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0]   tup_index_q, tup_row_q, tup_col_q;
    logic                       capture;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        err_d     = err_q;
        valid_d   = valid_q;
        capture   = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    index_d = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sweep_abort) begin
                    state_d = DONE;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A result arriving in the abort cycle needs no drain.
                if (sweep_abort) begin
                    state_d = div_valid ? DONE : DRAIN;
                end else if (div_valid) begin
                    if (div_dbz || div_ovf) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (sweep_abort) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end else if (node_ready) begin
                    valid_d = 1'b0;
                    if (index_q == LAST_INDEX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (div_valid) begin
                    state_d = DONE;
                end
            end
            ERROR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tup_index_q <= '0;
            tup_row_q   <= '0;
            tup_col_q   <= '0;
        end else if (capture) begin
            tup_index_q <= index_q;
            tup_row_q   <= div_q;
            tup_col_q   <= div_r;
        end
    end

`ifdef LBM_BOUNDARY_FLAG_EN
    logic boundary_next;
    logic boundary_q;

    lattice_boundary_detect #(
        .GRID_DIM      (GRID_DIM),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_boundary_detect (
        .row_i      (div_q),
        .col_i      (div_r),
        .boundary_o (boundary_next)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            boundary_q <= 1'b0;
        end else if (capture) begin
            boundary_q <= boundary_next;
        end
    end

    assign node_boundary = boundary_q;
`endif

    // Abort withdraws a presented tuple in the same cycle, so it beats node_ready.
    assign node_valid  = valid_q & ~sweep_abort;
    assign node_index  = tup_index_q;
    assign node_row    = tup_row_q;
    assign node_col    = tup_col_q;
    assign sweep_busy  = (state_q != IDLE);
    assign sweep_done  = (state_q == DONE);
    assign sweep_err   = err_q;
    assign div_x       = index_q;
    assign div_y       = DIVISOR;
    assign sweep_state = state_q;

endmodule

// File: tb/tb_lattice_sweep_sequencer.sv
// Self-checking bench for lattice_sweep_sequencer (GRID_DIM=4) with a behavioural
// 5-cycle divider; LBM_BOUNDARY_FLAG_EN also checks node_boundary.
module tb_lattice_sweep_sequencer;
    import lbm_pkg::*;

    localparam int G       = 4;
    localparam int AW      = $clog2(G * G);
    localparam int N       = G * G;
    localparam int DIV_LAT = 5;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          sweep_start = 1'b0;
    logic          sweep_abort = 1'b0;
    logic          node_ready = 1'b0;
    logic          sweep_busy, sweep_done, sweep_err, div_start, node_valid;
    logic [AW-1:0] div_x, div_y, node_index, node_row, node_col;
    logic          div_busy, div_valid, div_dbz, div_ovf;
    logic [AW-1:0] div_q, div_r;
    sweep_state_t  dbg_state;
`ifdef LBM_BOUNDARY_FLAG_EN
    logic          node_boundary;
`endif

    lattice_sweep_sequencer #(.GRID_DIM(G)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .sweep_start (sweep_start),
        .sweep_abort (sweep_abort),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_err   (sweep_err),
        .div_start   (div_start),
        .div_x       (div_x),
        .div_y       (div_y),
        .div_busy    (div_busy),
        .div_valid   (div_valid),
        .div_dbz     (div_dbz),
        .div_ovf     (div_ovf),
        .div_q       (div_q),
        .div_r       (div_r),
        .node_valid  (node_valid),
        .node_ready  (node_ready),
        .node_index  (node_index),
        .node_row    (node_row),
        .node_col    (node_col),
`ifdef LBM_BOUNDARY_FLAG_EN
        .node_boundary (node_boundary),
`endif
        .sweep_state (dbg_state)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural divider ----------------
    logic [AW-1:0] dv_x, dv_y;
    int            dv_cnt;
    int            inject_dbz_idx = -1;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_busy  <= 1'b0;
            div_valid <= 1'b0;
            div_dbz   <= 1'b0;
            div_ovf   <= 1'b0;
            div_q     <= '0;
            div_r     <= '0;
            dv_cnt    <= 0;
            dv_x      <= '0;
            dv_y      <= '0;
        end else begin
            div_valid <= 1'b0;
            div_dbz   <= 1'b0;
            if (div_busy) begin
                if (dv_cnt == 1) begin
                    div_busy  <= 1'b0;
                    div_valid <= 1'b1;
                    div_dbz   <= (dv_y == '0) || (int'(dv_x) == inject_dbz_idx);
                    div_q     <= (dv_y == '0) ? '1 : dv_x / dv_y;
                    div_r     <= (dv_y == '0) ? dv_x : dv_x % dv_y;
                end
                dv_cnt <= dv_cnt - 1;
            end else if (div_start) begin
                div_busy <= 1'b1;
                dv_cnt   <= DIV_LAT - 1;
                dv_x     <= div_x;
                dv_y     <= div_y;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [3*AW-1:0] exp_q[$];
    logic [3*AW-1:0] prev_tuple;
    logic            stall_prev;
    int n_checks, n_pass;
    int cyc, hs, done_cnt, done_cyc, dv_cyc, issues_in_abort, hs_in_abort, saw_idx3;
    int last_issue_x, ready_pct, stall_cnt;
    bit hold5;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference sweep: every node in order, row = index / G, col = index % G.
    task automatic fill_expected();
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back({AW'(i), AW'(i / G), AW'(i % G)});
    endtask

    task automatic clear_stats();
        hs = 0; done_cnt = 0; done_cyc = -1; dv_cyc = -1;
        issues_in_abort = 0; hs_in_abort = 0; saw_idx3 = 0; last_issue_x = -1;
    endtask

    task automatic monitor();
        logic [3*AW-1:0] t;
        logic [AW-1:0]   er, ec;
        if (div_start) begin
            last_issue_x = int'(div_x);
            if (sweep_abort) issues_in_abort++;
            check_eq("div_start_while_busy", div_busy, 0);
            check_eq("div_y", div_y, G);
            if (exp_q.size() > 0) check_eq("div_x", div_x, exp_q[0][3*AW-1:2*AW]);
            else check_eq("issue_unexpected", exp_q.size(), 1);
        end
        if (node_valid && node_index == 3) saw_idx3++;
        if (stall_prev && !sweep_abort) begin
            check_eq("hold_valid", node_valid, 1);
            check_eq("hold_tuple", {node_index, node_row, node_col}, prev_tuple);
        end
        if (node_valid && node_ready) begin
            hs++;
            if (sweep_abort) hs_in_abort++;
            if (exp_q.size() > 0) begin
                t  = exp_q.pop_front();
                er = t[2*AW-1:AW];
                ec = t[AW-1:0];
                check_eq("node_index", node_index, t[3*AW-1:2*AW]);
                check_eq("node_row", node_row, er);
                check_eq("node_col", node_col, ec);
`ifdef LBM_BOUNDARY_FLAG_EN
                check_eq("node_boundary", node_boundary,
                         (er == 0 || er == G - 1 || ec == 0 || ec == G - 1) ? 1 : 0);
`endif
            end else begin
                check_eq("tuple_unexpected", exp_q.size(), 1);
            end
        end
        stall_prev = node_valid && !node_ready;
        prev_tuple = {node_index, node_row, node_col};
        if (div_valid) dv_cyc = cyc;
        if (sweep_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // One clock: choose node_ready, observe settled outputs, cross the edge.
    task automatic tick();
        #1;
        if (hold5 && node_valid && node_index == 5 && stall_cnt < 10) begin
            node_ready = 1'b0;
            stall_cnt++;
        end else begin
            node_ready = ($urandom_range(0, 99) < ready_pct);
        end
        #1;
        monitor();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic start_sweep();
        fill_expected();
        clear_stats();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int b;
        b = budget;
        while (done_cnt == 0 && b > 0) begin
            tick();
            b--;
        end
        if (done_cnt == 0) check_eq("sweep_timeout", done_cnt, 1);
        tick();
        check_eq("idle_after_done", sweep_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        n_checks = 0; n_pass = 0; cyc = 0; stall_prev = 1'b0; prev_tuple = '0;
        ready_pct = 100; hold5 = 1'b0; stall_cnt = 0;
        clear_stats();

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_busy", sweep_busy, 0);
        check_eq("rst_done", sweep_done, 0);
        check_eq("rst_err", sweep_err, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_node_valid", node_valid, 0);
        check_eq("rst_div_y", div_y, G);
        check_eq("rst_div_x", div_x, 0);
        check_eq("rst_node_index", node_index, 0);
        check_eq("rst_state", dbg_state, IDLE);
`ifdef LBM_BOUNDARY_FLAG_EN
        check_eq("rst_boundary", node_boundary, 0);
`endif
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Full sweep, ready high, with a sweep_start pulse mid-sweep that must be ignored
        ready_pct = 100;
        start_sweep();
        repeat (20) tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        run_to_done(2000);
        check_eq("full_tuples", hs, N);
        check_eq("full_done_pulses", done_cnt, 1);
        check_eq("full_err", sweep_err, 0);
        check_eq("full_queue_empty", exp_q.size(), 0);

        // Backpressure on index 5 for 10 cycles, random ready elsewhere
        hold5 = 1'b1; stall_cnt = 0; ready_pct = 70;
        start_sweep();
        run_to_done(3000);
        hold5 = 1'b0;
        check_eq("bp_stall_cycles", stall_cnt, 10);
        check_eq("bp_tuples", hs, N);
        check_eq("bp_done_pulses", done_cnt, 1);

        // Abort while waiting on the divider for index 3
        ready_pct = 100;
        start_sweep();
        b = 500;
        while (last_issue_x != 3 && b > 0) begin
            tick();
            b--;
        end
        check_eq("abort_reached_idx3", last_issue_x, 3);
        sweep_abort = 1'b1;
        b = 200;
        while (done_cnt == 0 && b > 0) begin
            tick();
            b--;
        end
        sweep_abort = 1'b0;
        check_eq("abort_done_pulses", done_cnt, 1);
        check_eq("abort_done_after_div_valid", done_cyc - dv_cyc, 1);
        check_eq("abort_no_issue", issues_in_abort, 0);
        check_eq("abort_no_tuple3", saw_idx3, 0);
        check_eq("abort_tuples", hs, 3);
        tick();
        check_eq("abort_idle", sweep_busy, 0);

        // Divide-by-zero on index 2, then a clean restart
        inject_dbz_idx = 2;
        start_sweep();
        run_to_done(500);
        check_eq("dbz_err", sweep_err, 1);
        check_eq("dbz_tuples", hs, 2);
        check_eq("dbz_done_pulses", done_cnt, 1);
        repeat (3) tick();
        check_eq("dbz_err_sticky", sweep_err, 1);
        inject_dbz_idx = -1;
        start_sweep();
        check_eq("restart_err_cleared", sweep_err, 0);
        run_to_done(2000);
        check_eq("restart_tuples", hs, N);
        check_eq("restart_err", sweep_err, 0);

        // Asynchronous reset while a tuple is being presented
        ready_pct = 0;
        start_sweep();
        b = 100;
        while (!node_valid && b > 0) begin
            tick();
            b--;
        end
        check_eq("pre_reset_valid", node_valid, 1);
        repeat (2) tick();
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("arst_node_valid", node_valid, 0);
        check_eq("arst_busy", sweep_busy, 0);
        check_eq("arst_div_start", div_start, 0);
        check_eq("arst_done", sweep_done, 0);
        check_eq("arst_div_x", div_x, 0);
        @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
        @(posedge Clk);
        #1;
        check_eq("post_reset_idle", sweep_busy, 0);

        // Random sweeps with random ready and a randomly timed abort
        for (int k = 0; k < 4; k++) begin
            int ab;
            ab = $urandom_range(5, 150);
            ready_pct = $urandom_range(30, 100);
            start_sweep();
            while (done_cnt == 0 && ab > 0) begin
                tick();
                ab--;
            end
            if (done_cnt == 0) begin
                sweep_abort = 1'b1;
                issues_in_abort = 0;
                hs_in_abort = 0;
            end
            run_to_done(200);
            sweep_abort = 1'b0;
            check_eq("rand_done_pulses", done_cnt, 1);
            check_eq("rand_no_issue_in_abort", issues_in_abort, 0);
            check_eq("rand_no_hs_in_abort", hs_in_abort, 0);
            check_eq("rand_err", sweep_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lattice_sweep_sequencer.md
Name: lattice_sweep_sequencer

Overview:
- Sequences one shared multi-cycle integer divider to sweep every lattice node index 0..GRID_DIM*GRID_DIM-1 in order.
- For each index, splits it into row (quotient) and column (remainder) and hands the result downstream over a valid/ready handshake.
- Sits between the LBM step controller (start/done) and the streaming/collision address logic.

Parameters:
- GRID_DIM, 16, lattice edge length in nodes; must be >= 2.
- ADDRESS_WIDTH, $clog2(GRID_DIM*GRID_DIM), width of node index, row, column and divider operands.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- sweep_start  in  1  one-cycle pulse; begins a sweep, honoured only in IDLE.
- sweep_abort  in  1  level or pulse; ends the sweep early.
- sweep_busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse when the sweep completes or abort finishes draining.
- sweep_err  out  1  sticky; set on divider dbz/ovf; cleared by the next accepted sweep_start.
- div_start  out  1  one-cycle start pulse to the divider.
- div_x  out  ADDRESS_WIDTH  dividend, equal to the current node index.
- div_y  out  ADDRESS_WIDTH  divisor, constant GRID_DIM.
- div_busy, div_valid, div_dbz, div_ovf  in  1 each  divider status.
- div_q, div_r  in  ADDRESS_WIDTH each  quotient and remainder.
- node_valid  out  1  output tuple valid.
- node_ready  in  1  downstream accept.
- node_index, node_row, node_col  out  ADDRESS_WIDTH each  output tuple.

Behaviour:
- Reset: state IDLE; index 0; every output 0 except div_y = GRID_DIM.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DRAIN, ERROR, DONE.
- IDLE:
  - On sweep_start, clear index and sweep_err, then go to ISSUE.
  - sweep_start in any other state is ignored.
- ISSUE:
  - Assert div_start for exactly 1 cycle, only when div_busy = 0; otherwise stall in ISSUE.
  - div_x holds the index and stays stable from ISSUE until div_valid.
  - Then go to WAIT.
- WAIT:
  - On div_valid with dbz or ovf: set sweep_err and go to ERROR.
  - On div_valid otherwise: register q into node_row, r into node_col, index into node_index; set node_valid; go to PRESENT.
- PRESENT:
  - node_valid and the tuple stay stable until node_ready = 1.
  - On the handshake cycle, node_valid drops the next cycle.
  - If index == GRID_DIM*GRID_DIM-1, go to DONE; else increment index and go to ISSUE.
  - Throughput: at most one tuple per (divider latency + 2) cycles.
- sweep_abort:
  - In ISSUE before div_start is issued: go straight to DONE.
  - In WAIT: go to DRAIN, wait for div_valid, discard the result, then DONE.
  - In PRESENT: drop node_valid immediately (the tuple is not delivered), then go to DONE.
  - Abort and node_ready in the same cycle: abort wins.
- ERROR: one cycle, then DONE. Remaining indices are skipped.
- DONE: pulse sweep_done for 1 cycle, then IDLE.
- Index arithmetic: unsigned. Last index is compared explicitly, so the index never wraps.
- Asynchronous reset mid-sweep: return to IDLE immediately. A divider result still in flight is not waited on; the divider is reset by the same Reset_n.

Optional Feature:
- Macro: LBM_BOUNDARY_FLAG_EN.
- Defined:
  - Adds output node_boundary (1 bit), registered together with the tuple.
  - node_boundary = 1 when row == 0, row == GRID_DIM-1, col == 0 or col == GRID_DIM-1.
  - Reset value 0.
- Undefined: the port is absent and there is no added logic.

Decomposition:
- Package lbm_pkg:
  - sweep_state_t enum.
  - Function node_count(GRID_DIM) returning GRID_DIM*GRID_DIM.
  - Localparam for the default GRID_DIM.
- Sub-module lattice_boundary_detect (combinational row/col edge compare). Instantiated only under LBM_BOUNDARY_FLAG_EN.
- The divider is external and connected by the parent.

Test Plan (GRID_DIM=4 with a behavioural divider of 5-cycle latency unless stated):
- Full sweep, node_ready tied high -> exactly 16 tuples in index order 0..15; index 6 gives row 1, col 2; index 15 gives row 3, col 3; one sweep_done pulse; sweep_err = 0.
- Backpressure: hold node_ready low 10 cycles on index 5 -> tuple (5,1,1) held stable and not duplicated; index 6 issued only after the handshake.
- Abort during WAIT on index 3 -> no div_start until div_valid; no tuple 3 presented; sweep_done 1 cycle after div_valid; return to IDLE.
- Force div_dbz on index 2 -> sweep_err set, sweep_done pulses; next sweep_start clears sweep_err and the sweep restarts at 0.
- Reset_n asserted mid-PRESENT -> node_valid, sweep_busy and div_start are 0 asynchronously; sweep_start during busy is ignored.
- With LBM_BOUNDARY_FLAG_EN defined: node_boundary = 1 for indices 0, 3, 4, 12, 15 and 0 for indices 5, 6, 9, 10.
